// File: rtl/normalising_pipeline_if.sv
// Stream bus for normalising_pipeline: one input beat channel and one output beat channel.
// Handshake: a beat transfers on a rising edge where valid && ready are both high. The
// source holds valid and data stable until that edge and never waits for ready before
// raising valid. Ready may fall without a transfer.
// master = the side feeding input beats and consuming output beats; slave = the block.
interface normalising_pipeline_if #(
    parameter int IN_W     = 18,
    parameter int OUT_W    = 8,
    parameter int CHANNELS = 2,
    parameter int PIXW     = 24
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;
    logic [PIXW-1:0]           out_addr;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/normalising_pipeline.sv
// normalising_pipeline: multi-channel normaliser for the Gaussian buffer path.
// Each channel sum is multiplied by a fixed reciprocal and shifted right (a cheap
// divide), then saturated to OUT_W bits. Output beats carry their pixel address.
// A start pulse arms one frame pass START_ADDR..END_ADDR; the pipe then drains and
// pulses done.
// Optional feature macro: NORMALISE_ROUND_EN (round-half-up; default build truncates).
module normalising_pipeline #(
    parameter int                 IN_W        = 18,
    parameter int                 OUT_W       = 8,
    parameter int                 CHANNELS    = 2,
    parameter int                 RECIP_W     = 16,
    parameter logic [RECIP_W-1:0] RECIP       = RECIP_W'(22920),
    parameter int                 RECIP_SHIFT = 24,
    parameter int                 START_ADDR  = 770,
    parameter int                 END_ADDR    = 523518,
    parameter int                 COUNTSTEP   = 2,
    parameter int                 PIXW        = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    normalising_pipeline_if.slave       bus,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);
    localparam int PROD_W = IN_W + RECIP_W;
    // One spare bit so that adding the rounding bias to a full-scale product cannot overflow.
    localparam int SUM_W  = PROD_W + 1;

`ifdef NORMALISE_ROUND_EN
    localparam logic [SUM_W-1:0] BIAS = SUM_W'(1) << (RECIP_SHIFT - 1);
`else
    localparam logic [SUM_W-1:0] BIAS = '0;
`endif
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [PIXW-1:0]           addr_cnt;
    logic                      en;
    logic                      accept;
    logic                      last_beat;

    logic                      s1_valid;
    logic [PIXW-1:0]           s1_addr;
    logic [PROD_W-1:0]         s1_prod [CHANNELS];

    logic [SUM_W-1:0]          sum;
    logic [SUM_W-1:0]          scaled;
    logic [CHANNELS*OUT_W-1:0] result;

    // Both stages move together; a stalled output beat freezes the whole pipe.
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == S_RUN) && en;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = accept && (addr_cnt >= PIXW'(END_ADDR));

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next-state: frame pass, drain until both stages are empty, one-cycle done.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_beat) state_next = S_DRAIN;
            S_DRAIN: if (!s1_valid && !bus.out_valid) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pixel address counter: loaded on an accepted start, advanced per accepted beat.
    always_ff @(posedge clk) begin
        if (reset)                          addr_cnt <= '0;
        else if (state == S_IDLE && start)  addr_cnt <= PIXW'(START_ADDR);
        else if (accept)                    addr_cnt <= addr_cnt + PIXW'(COUNTSTEP);
    end

    // Stage 1: capture per-channel products and the beat's address.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            for (int c = 0; c < CHANNELS; c++) s1_prod[c] <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= addr_cnt;
                for (int c = 0; c < CHANNELS; c++)
                    s1_prod[c] <= PROD_W'(bus.in_data[c*IN_W +: IN_W]) * PROD_W'(RECIP);
            end
        end
    end

    // Bias, shift and saturate each channel product.
    always_comb begin
        result = '0;
        sum    = '0;
        scaled = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum    = {1'b0, s1_prod[c]} + BIAS;
            scaled = sum >> RECIP_SHIFT;
            if (scaled > SAT_MAX) result[c*OUT_W +: OUT_W] = {OUT_W{1'b1}};
            else                  result[c*OUT_W +: OUT_W] = scaled[OUT_W-1:0];
        end
    end

    // Stage 2: output register, holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
        end else if (en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data <= result;
                bus.out_addr <= s1_addr;
            end
        end
    end
endmodule
